// File: rtl/brisc_pkg.sv
// ============================================================================
// Module  : brisc_pkg
// Brief   : Shared core widths and register-file constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package brisc_pkg;

  localparam int XLEN          = 32;
  localparam int REG_BITS      = 5;
  localparam int NUM_REGS      = 1 << REG_BITS;
  localparam int PEND_BITS_DEF = 2;

  function automatic logic reg_is_x0(input logic [REG_BITS-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_pend_ctr.sv
// ============================================================================
// Module  : rf_pend_ctr
// Brief   : Per-register in-flight write counters with saturating issue gate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_pend_ctr
  import brisc_pkg::*;
#(
  parameter int PEND_BITS = PEND_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_BITS-1:0]  issue_rd,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [REG_BITS-1:0]  wb_rd,
  input  logic [REG_BITS-1:0]  rs1,
  input  logic [REG_BITS-1:0]  rs2,
  output logic [PEND_BITS-1:0] rs1_cnt,
  output logic [PEND_BITS-1:0] rs2_cnt
);

  localparam logic [PEND_BITS-1:0] C_CNT_MAX = '1;

  logic [PEND_BITS-1:0] r_cnt [NUM_REGS];
  logic [NUM_REGS-1:1]  w_inc;
  logic [NUM_REGS-1:1]  w_dec;
  logic                 w_issue_fire;

  assign issue_ready  = reg_is_x0(issue_rd) || (r_cnt[issue_rd] != C_CNT_MAX);
  assign w_issue_fire = issue_valid && issue_ready;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc[i] = w_issue_fire && (issue_rd == REG_BITS'(i));
      w_dec[i] = wb_valid && (wb_rd == REG_BITS'(i));
    end
  end

  // Simultaneous issue and writeback cancel; decrement floors at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign rs1_cnt = r_cnt[rs1];
  assign rs2_cnt = r_cnt[rs2];

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module  : regfile_sb
// Brief   : Register file with write scoreboard; RF_BYPASS_EN adds writeback
//           forwarding of data and busy onto the read ports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import brisc_pkg::*;
#(
  parameter int PEND_BITS = PEND_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs1_in,
  input  logic [REG_BITS-1:0] rs2_in,
  output logic [XLEN-1:0]     rs1_data_out,
  output logic [XLEN-1:0]     rs2_data_out,
  output logic                rs1_busy_out,
  output logic                rs2_busy_out,
  input  logic                issue_valid_in,
  input  logic [REG_BITS-1:0] issue_rd_in,
  output logic                issue_ready_out,
  input  logic                write_rf_in,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic [XLEN-1:0]     rd_data_in
);

  logic [XLEN-1:0]      r_regs [NUM_REGS];
  logic                 w_wb_en;
  logic [PEND_BITS-1:0] w_rs1_cnt;
  logic [PEND_BITS-1:0] w_rs2_cnt;
  logic [XLEN-1:0]      w_rs1_stored;
  logic [XLEN-1:0]      w_rs2_stored;

  // Gated by reset so a writeback cannot leak onto the bypass path while held.
  assign w_wb_en = reset && write_rf_in && !reg_is_x0(rd_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[rd_in] <= rd_data_in;
    end
  end

  assign w_rs1_stored = reg_is_x0(rs1_in) ? '0 : r_regs[rs1_in];
  assign w_rs2_stored = reg_is_x0(rs2_in) ? '0 : r_regs[rs2_in];

  rf_pend_ctr #(
    .PEND_BITS (PEND_BITS)
  ) u_pend_ctr (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid_in),
    .issue_rd    (issue_rd_in),
    .issue_ready (issue_ready_out),
    .wb_valid    (w_wb_en),
    .wb_rd       (rd_in),
    .rs1         (rs1_in),
    .rs2         (rs2_in),
    .rs1_cnt     (w_rs1_cnt),
    .rs2_cnt     (w_rs2_cnt)
  );

`ifdef RF_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = w_wb_en && (rs1_in == rd_in);
  assign w_rs2_hit = w_wb_en && (rs2_in == rd_in);

  // A hitting writeback retires one pending write, so busy needs another behind it.
  assign rs1_data_out = w_rs1_hit ? rd_data_in : w_rs1_stored;
  assign rs2_data_out = w_rs2_hit ? rd_data_in : w_rs2_stored;
  assign rs1_busy_out = w_rs1_hit ? (w_rs1_cnt > PEND_BITS'(1)) : (w_rs1_cnt != '0);
  assign rs2_busy_out = w_rs2_hit ? (w_rs2_cnt > PEND_BITS'(1)) : (w_rs2_cnt != '0);
`else
  assign rs1_data_out = w_rs1_stored;
  assign rs2_data_out = w_rs2_stored;
  assign rs1_busy_out = (w_rs1_cnt != '0);
  assign rs2_busy_out = (w_rs2_cnt != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module  : tb_regfile_sb
// Brief   : Directed self-checking bench for regfile_sb (either RF_BYPASS_EN build).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;
  import brisc_pkg::*;

  logic                clk;
  logic                reset;
  logic [REG_BITS-1:0] rs1_in;
  logic [REG_BITS-1:0] rs2_in;
  logic [XLEN-1:0]     rs1_data_out;
  logic [XLEN-1:0]     rs2_data_out;
  logic                rs1_busy_out;
  logic                rs2_busy_out;
  logic                issue_valid_in;
  logic [REG_BITS-1:0] issue_rd_in;
  logic                issue_ready_out;
  logic                write_rf_in;
  logic [REG_BITS-1:0] rd_in;
  logic [XLEN-1:0]     rd_data_in;

  int checks;
  int errors;

  regfile_sb dut (
    .clk             (clk),
    .reset           (reset),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rs1_data_out    (rs1_data_out),
    .rs2_data_out    (rs2_data_out),
    .rs1_busy_out    (rs1_busy_out),
    .rs2_busy_out    (rs2_busy_out),
    .issue_valid_in  (issue_valid_in),
    .issue_rd_in     (issue_rd_in),
    .issue_ready_out (issue_ready_out),
    .write_rf_in     (write_rf_in),
    .rd_in           (rd_in),
    .rd_data_in      (rd_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    rs1_in         = '0;
    rs2_in         = '0;
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd7;
    write_rf_in    = 1'b1;
    rd_in          = 5'd1;
    rd_data_in     = 32'hFFFF_FFFF;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rs1_in = 5'd1;
    rs2_in = 5'd7;
    #1;
    checks++;
    if (issue_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", issue_ready_out);
    end
    checks++;
    if (rs1_data_out !== 32'h0 || rs2_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: data1 %h busy2 %b expected 0/0", rs1_data_out, rs2_busy_out);
    end
    issue_valid_in = 1'b0;
    write_rf_in    = 1'b0;
    rd_in          = '0;
    rd_data_in     = '0;
    #1 reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rs1_in = REG_BITS'(i);
      rs2_in = REG_BITS'(32 - i);
      #1;
      checks++;
      if (rs1_data_out !== 32'h0 || rs2_data_out !== 32'h0 ||
          rs1_busy_out !== 1'b0 || rs2_busy_out !== 1'b0 || issue_ready_out !== 1'b1) begin
        errors++;
        $display("FAIL reset_read x%0d: d1 %h d2 %h b1 %b b2 %b rdy %b expected 0 0 0 0 1",
                 i, rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, issue_ready_out);
      end
    end
  endtask

  task automatic test_issue_writeback();
    tick();
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd5;
    tick();
    issue_valid_in = 1'b0;
    rs1_in         = 5'd5;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL issue_busy x5: got %b expected 1", rs1_busy_out);
    end
    write_rf_in = 1'b1;
    rd_in       = 5'd5;
    rd_data_in  = 32'hDEAD_BEEF;
    tick();
    write_rf_in = 1'b0;
    #1;
    checks++;
    if (rs1_data_out !== 32'hDEAD_BEEF || rs1_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL wb_x5: data %h busy %b expected deadbeef 0", rs1_data_out, rs1_busy_out);
    end
  endtask

  task automatic test_saturate();
    rs1_in         = 5'd7;
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (issue_ready_out !== 1'b1) begin
        errors++;
        $display("FAIL sat_ready_%0d: got %b expected 1", k, issue_ready_out);
      end
      tick();
    end
    #1;
    checks++;
    if (issue_ready_out !== 1'b0 || rs1_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL sat_full x7: ready %b busy %b expected 0 1", issue_ready_out, rs1_busy_out);
    end
    issue_rd_in = 5'd8;
    #1;
    checks++;
    if (issue_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL sat_other x8: ready %b expected 1", issue_ready_out);
    end
    issue_rd_in = 5'd7;
    tick();
    issue_valid_in = 1'b0;
    rd_in          = 5'd7;
    for (int k = 0; k < 3; k++) begin
      write_rf_in = 1'b1;
      rd_data_in  = 32'h70 + 32'(k);
      tick();
      write_rf_in = 1'b0;
      #1;
      checks++;
      if (rs1_busy_out !== (k < 2)) begin
        errors++;
        $display("FAIL sat_drain_%0d: busy %b expected %b", k, rs1_busy_out, (k < 2));
      end
    end
    checks++;
    if (rs1_data_out !== 32'h72) begin
      errors++;
      $display("FAIL sat_data x7: got %h expected 72", rs1_data_out);
    end
  endtask

  task automatic test_same_cycle();
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd3;
    tick();
    write_rf_in = 1'b1;
    rd_in       = 5'd3;
    rd_data_in  = 32'h33;
    #1;
    checks++;
    if (issue_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL same_ready x3: got %b expected 1", issue_ready_out);
    end
    tick();
    issue_valid_in = 1'b0;
    write_rf_in    = 1'b0;
    rs1_in         = 5'd3;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b1 || rs1_data_out !== 32'h33) begin
      errors++;
      $display("FAIL same_hold x3: busy %b data %h expected 1 33", rs1_busy_out, rs1_data_out);
    end
    write_rf_in = 1'b1;
    tick();
    write_rf_in = 1'b0;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL same_drain x3: busy %b expected 0", rs1_busy_out);
    end
    write_rf_in    = 1'b1;
    rd_in          = 5'd0;
    rd_data_in     = 32'h1234;
    rs2_in         = 5'd0;
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd0;
    #1;
    checks++;
    if (issue_ready_out !== 1'b1 || rs2_data_out !== 32'h0) begin
      errors++;
      $display("FAIL x0_issue: ready %b data %h expected 1 0", issue_ready_out, rs2_data_out);
    end
    tick();
    write_rf_in    = 1'b0;
    issue_valid_in = 1'b0;
    #1;
    checks++;
    if (rs2_data_out !== 32'h0 || rs2_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL x0_write: data %h busy %b expected 0 0", rs2_data_out, rs2_busy_out);
    end
    // Writeback with nothing pending must not wrap the counter.
    write_rf_in = 1'b1;
    rd_in       = 5'd10;
    rd_data_in  = 32'hAA;
    tick();
    write_rf_in = 1'b0;
    rs1_in      = 5'd10;
    issue_rd_in = 5'd10;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b0 || issue_ready_out !== 1'b1 || rs1_data_out !== 32'hAA) begin
      errors++;
      $display("FAIL underflow x10: busy %b ready %b data %h expected 0 1 aa",
               rs1_busy_out, issue_ready_out, rs1_data_out);
    end
  endtask

  task automatic test_bypass();
    write_rf_in = 1'b1;
    rd_in       = 5'd9;
    rd_data_in  = 32'h1111_1111;
    tick();
    write_rf_in    = 1'b0;
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd9;
    tick();
    issue_valid_in = 1'b0;
    rs2_in         = 5'd9;
    write_rf_in    = 1'b1;
    rd_in          = 5'd9;
    rd_data_in     = 32'hA5A5_A5A5;
    #1;
`ifdef RF_BYPASS_EN
    checks++;
    if (rs2_data_out !== 32'hA5A5_A5A5 || rs2_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL bypass x9: data %h busy %b expected a5a5a5a5 0", rs2_data_out, rs2_busy_out);
    end
`else
    checks++;
    if (rs2_data_out !== 32'h1111_1111 || rs2_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL nobypass x9: data %h busy %b expected 11111111 1", rs2_data_out, rs2_busy_out);
    end
`endif
    tick();
    write_rf_in = 1'b0;
    #1;
    checks++;
    if (rs2_data_out !== 32'hA5A5_A5A5 || rs2_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL after_wb x9: data %h busy %b expected a5a5a5a5 0", rs2_data_out, rs2_busy_out);
    end
  endtask

  task automatic test_reset_mid();
    write_rf_in = 1'b1;
    rd_in       = 5'd4;
    rd_data_in  = 32'h44;
    tick();
    write_rf_in    = 1'b0;
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd4;
    tick();
    tick();
    rs1_in = 5'd4;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b1 || rs1_data_out !== 32'h44) begin
      errors++;
      $display("FAIL pre_reset x4: busy %b data %h expected 1 44", rs1_busy_out, rs1_data_out);
    end
    write_rf_in = 1'b1;
    rd_data_in  = 32'hFF;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b0 || rs1_data_out !== 32'h0 || issue_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset x4: busy %b data %h ready %b expected 0 0 1",
               rs1_busy_out, rs1_data_out, issue_ready_out);
    end
    issue_valid_in = 1'b0;
    write_rf_in    = 1'b0;
    #1 reset = 1'b1;
    issue_valid_in = 1'b1;
    tick();
    issue_valid_in = 1'b0;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_issue x4: busy %b expected 1", rs1_busy_out);
    end
    write_rf_in = 1'b1;
    rd_data_in  = 32'h55;
    tick();
    write_rf_in = 1'b0;
    #1;
    checks++;
    if (rs1_busy_out !== 1'b0 || rs1_data_out !== 32'h55) begin
      errors++;
      $display("FAIL post_reset_wb x4: busy %b data %h expected 0 55", rs1_busy_out, rs1_data_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_issue_writeback();
    test_saturate();
    test_same_cycle();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter PEND_BITS, default 2, per-register in-flight write counter width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port rs1_in  input  REG_BITS  read address, port 1.
REQ-005 SHALL have port rs2_in  input  REG_BITS  read address, port 2.
REQ-006 SHALL have port rs1_data_out  output  XLEN  read data, port 1.
REQ-007 SHALL have port rs2_data_out  output  XLEN  read data, port 2.
REQ-008 SHALL have port rs1_busy_out  output  1  rs1 has a write in flight.
REQ-009 SHALL have port rs2_busy_out  output  1  rs2 has a write in flight.
REQ-010 SHALL have port issue_valid_in  input  1  an instruction writing issue_rd_in is issuing.
REQ-011 SHALL have port issue_rd_in  input  REG_BITS  destination of the issuing instruction.
REQ-012 SHALL have port issue_ready_out  output  1  issue accepted this cycle.
REQ-013 SHALL have port write_rf_in  input  1  writeback write enable.
REQ-014 SHALL have port rd_in  input  REG_BITS  writeback destination.
REQ-015 SHALL have port rd_data_in  input  XLEN  writeback data.

Function
REQ-016 SHALL hold NUM_REGS x XLEN registers; write rd_data_in to rd_in on a rising edge when write_rf_in=1 and rd_in!=0.
REQ-017 SHALL read combinationally; x0 always reads 0; writes to x0 ignored.
REQ-018 SHALL hold one PEND_BITS counter per register; x0 counter constant 0.
REQ-019 Issue handshake: accept when issue_valid_in & issue_ready_out; issue_ready_out = 0 only when counter[issue_rd_in] is at max (2^PEND_BITS-1); issue_rd_in=0 always ready, no count.
REQ-020 Accepted issue SHALL increment counter[issue_rd_in] next edge.
REQ-021 Writeback with write_rf_in=1, rd_in!=0 SHALL decrement counter[rd_in] next edge; at 0 it SHALL stay 0 (no wrap), data still written.
REQ-022 Accepted issue and writeback to the same register in one cycle SHALL leave the counter unchanged; at max, ready stays 0 regardless of the same-cycle writeback.
REQ-023 rsN_busy_out SHALL be 1 iff counter[rsN_in]!=0 (subject to REQ-028); rsN_in=0 never busy.
REQ-024 Write-then-read latency SHALL be one cycle without bypass, zero with bypass.

Reset
REQ-025 reset low SHALL asynchronously clear all registers and all counters to 0.
REQ-026 During reset: rs*_data_out=0, rs*_busy_out=0, issue_ready_out=1; issue/writeback inputs ignored.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight counts; first edge after release behaves as from empty.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: read port whose address equals rd_in (nonzero) while write_rf_in=1 SHALL return rd_data_in, and its busy SHALL be computed on the counter minus that writeback (busy only if count>1).
REQ-029 RF_BYPASS_EN undefined: read data from storage only; busy from counter only; no rd_in comparators.

Structure
REQ-030 XLEN, REG_BITS, NUM_REGS SHALL come from brisc_pkg; PEND_BITS default SHALL be a brisc_pkg constant.
REQ-031 Counter array with increment/decrement/saturate logic SHALL be sub-module rf_pend_ctr; storage and bypass stay in regfile_sb.

Verification
REQ-032 Reset, then read x1..x31 -> all data 0, busy 0, issue_ready_out 1.
REQ-033 Issue rd=5; next cycle rs1_in=5 -> rs1_busy_out=1; writeback rd=5 data 0xDEADBEEF -> next cycle rs1_data_out=0xDEADBEEF, busy 0.
REQ-034 Three issues to x7 (PEND_BITS=2) -> issue_ready_out=0 for x7; fourth issue not counted; three writebacks -> busy 0.
REQ-035 Same cycle issue and writeback to x3 with count 1 -> count stays 1, busy stays 1; writeback x0 data 0x1234 -> x0 reads 0.
REQ-036 RF_BYPASS_EN: writeback x9=0xA5A5A5A5 with rs2_in=9 same cycle, count 1 -> rs2_data_out=0xA5A5A5A5, rs2_busy_out=0; undefined -> old value, busy 1.
REQ-037 Reset pulsed low with x4 count 2 -> x4 busy 0, data 0 immediately, before next clock edge.
